// File: rtl/uart_reg_bridge.sv
// Byte-level command responder between a UART and a one-cycle-strobe register bus.
// Frames: 'W' addr data -> 'K'; 'R' addr -> read byte; anything else -> '?'.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for a command byte
// S_ADDR    | command seen, waiting for the address byte
// S_DATA    | write address seen, waiting for the data byte
// S_WRITE   | bus_we strobe cycle, loads the 'K' reply
// S_READ    | bus_re strobe cycle
// S_CAPTURE | bus_rdata valid, loaded into tx_data
// S_REPLY   | waiting for the transmitter, then one tx_wr pulse
module uart_reg_bridge #(
    parameter int unsigned timeout_cycles = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_avail,
    input  logic       rx_error,
    output logic       rx_ack,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_busy,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_re,
    input  logic [7:0] bus_rdata,
    output logic [7:0] err_count
);
    localparam int TW = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(timeout_cycles - 1);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h4B;
    localparam logic [7:0] RSP_BAD   = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_WRITE, S_READ, S_CAPTURE, S_REPLY
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          is_write;
    logic          frame_state;
    logic          take_err;
    logic          take_byte;
    logic [7:0]    err_inc;

    // rx_avail/rx_error are stale while rx_ack is high; the UART clears them one edge later
    assign frame_state = (state == S_IDLE) || (state == S_ADDR) || (state == S_DATA);
    assign take_err    = frame_state && rx_error && !rx_ack;
    assign take_byte   = frame_state && rx_avail && !rx_error && !rx_ack;
    assign err_inc     = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            is_write  <= 1'b0;
            rx_ack    <= 1'b0;
            tx_data   <= 8'h00;
            tx_wr     <= 1'b0;
            bus_addr  <= 8'h00;
            bus_wdata <= 8'h00;
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
            err_count <= 8'h00;
        end else begin
            rx_ack <= 1'b0;
            bus_we <= 1'b0;
            bus_re <= 1'b0;
            if (take_err) begin
                rx_ack    <= 1'b1;
                timer     <= '0;
                err_count <= err_inc;
                state     <= S_IDLE;
            end else if (take_byte) begin
                rx_ack <= 1'b1;
                timer  <= '0;
                case (state)
                    S_IDLE: begin
                        if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                            is_write <= (rx_data == CMD_WRITE);
                            state    <= S_ADDR;
                        end else begin
                            tx_data   <= RSP_BAD;
                            err_count <= err_inc;
                            state     <= S_REPLY;
                        end
                    end
                    S_ADDR: begin
                        bus_addr <= rx_data;
                        if (is_write) begin
                            state <= S_DATA;
                        end else begin
                            bus_re <= 1'b1;
                            state  <= S_READ;
                        end
                    end
                    default: begin
                        bus_wdata <= rx_data;
                        bus_we    <= 1'b1;
                        state     <= S_WRITE;
                    end
                endcase
            end else begin
                case (state)
                    S_ADDR, S_DATA: begin
                        if (timer == TIMER_LAST) begin
                            timer     <= '0;
                            err_count <= err_inc;
                            state     <= S_IDLE;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    S_WRITE: begin
                        tx_data <= RSP_ACK;
                        state   <= S_REPLY;
                    end
                    S_READ: state <= S_CAPTURE;
                    // request transmit here already so a read reply lands on the same cycle as a write reply
                    S_CAPTURE: begin
                        tx_data <= bus_rdata;
                        tx_wr   <= !tx_busy;
                        state   <= S_REPLY;
                    end
                    S_REPLY: begin
                        if (tx_wr) begin
                            tx_wr <= 1'b0;
                            state <= S_IDLE;
                        end else if (!tx_busy) begin
                            tx_wr <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge: UART byte model, register-bus slave memory,
// and a frame-level scoreboard of expected strobes and replies with latency checks.
module tb_uart_reg_bridge;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_avail, rx_error, rx_ack;
    logic [7:0] tx_data;
    logic       tx_wr, tx_busy;
    logic [7:0] bus_addr, bus_wdata, bus_rdata, err_count;
    logic       bus_we, bus_re;

    uart_reg_bridge #(.timeout_cycles(100)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_avail(rx_avail), .rx_error(rx_error), .rx_ack(rx_ack),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
    typedef struct packed { logic [7:0] d; int lat; } tx_t;  // lat 0: relative to tx_busy falling

    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    tx_t        exp_tx[$];
    wr_t        mw;
    tx_t        mt;
    logic [7:0] ma;
    logic [7:0] model_mem [256];
    logic [7:0] slave_mem [256];
    logic [7:0] last_tx = 8'h00;
    int last_ack = -100;
    int busy_fall = -100;
    int exp_err = 0;
    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // register slave: read data appears the cycle after bus_re
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) slave_mem[i] <= 8'h00;
            slave_mem[8'h22] <= 8'h3C;
            bus_rdata <= 8'h00;
        end else begin
            if (bus_we) slave_mem[bus_addr] <= bus_wdata;
            if (bus_re) bus_rdata <= slave_mem[bus_addr];
        end
    end

    always @(negedge clk) begin
        if (rx_ack) last_ack = cyc;
        if (bus_we) begin
            if (exp_wr.size() == 0) chk("unexpected bus_we", 1, 0);
            else begin
                mw = exp_wr.pop_front();
                chk("write addr", bus_addr, mw.a);
                chk("write data", bus_wdata, mw.d);
                chk("bus_we latency", rx_ack, 1);
            end
        end
        if (bus_re) begin
            if (exp_rd.size() == 0) chk("unexpected bus_re", 1, 0);
            else begin
                ma = exp_rd.pop_front();
                chk("read addr", bus_addr, ma);
                chk("bus_re latency", rx_ack, 1);
            end
        end
        if (tx_wr) begin
            if (exp_tx.size() == 0) chk("unexpected tx_wr", 1, 0);
            else begin
                mt = exp_tx.pop_front();
                chk("reply data", tx_data, mt.d);
                if (mt.lat > 0) chk("reply latency", cyc - last_ack, mt.lat);
                else            chk("reply after busy fall", cyc - busy_fall, 1);
                chk("tx_wr while busy", tx_busy, 0);
            end
            last_tx = tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        rx_data  = b;
        rx_avail = 1'b1;
        do begin @(negedge clk); k++; end while (!rx_ack && k < 50);
        if (!rx_ack) chk("rx_ack wait for byte", 0, 1);
        rx_avail = 1'b0;
    endtask

    task automatic send_error();
        int k = 0;
        rx_error = 1'b1;
        do begin @(negedge clk); k++; end while (!rx_ack && k < 50);
        if (!rx_ack) chk("rx_ack wait for error", 0, 1);
        rx_error = 1'b0;
        exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_wr.size() + exp_rd.size() + exp_tx.size()) != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("pending expectations", exp_wr.size() + exp_rd.size() + exp_tx.size(), 0);
        repeat (4) @(negedge clk);
        chk("err_count", err_count, exp_err);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        exp_wr.push_back(wr_t'{a: a, d: d});
        exp_tx.push_back(tx_t'{d: 8'h4B, lat: 2});
        model_mem[a] = d;
        send_byte(8'h57);
        send_byte(a);
        send_byte(d);
        drain();
    endtask

    task automatic do_read(input logic [7:0] a);
        exp_rd.push_back(a);
        exp_tx.push_back(tx_t'{d: model_mem[a], lat: 2});
        send_byte(8'h52);
        send_byte(a);
        drain();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, " rx_ack"}, rx_ack, 0);
        chk({tag, " tx_wr"}, tx_wr, 0);
        chk({tag, " bus_we"}, bus_we, 0);
        chk({tag, " bus_re"}, bus_re, 0);
        chk({tag, " tx_data"}, tx_data, 0);
        chk({tag, " bus_addr"}, bus_addr, 0);
        chk({tag, " bus_wdata"}, bus_wdata, 0);
        chk({tag, " err_count"}, err_count, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        model_mem[8'h22] = 8'h3C;
        reset = 1'b1; rx_data = 8'h00; rx_avail = 1'b0; rx_error = 1'b0; tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        do_write(8'h10, 8'hA5);
        chk("held bus_addr", bus_addr, 8'h10);
        chk("held bus_wdata", bus_wdata, 8'hA5);
        chk("err after write", err_count, 0);

        do_read(8'h22);
        chk("read reply literal", last_tx, 8'h3C);

        exp_tx.push_back(tx_t'{d: 8'h3F, lat: 1});
        exp_err++;
        send_byte(8'h41);
        drain();
        chk("unknown cmd reply literal", last_tx, 8'h3F);
        chk("err after unknown", err_count, 1);
        do_read(8'h10);
        chk("readback literal", last_tx, 8'hA5);

        send_byte(8'h57);
        send_byte(8'h10);
        repeat (150) @(negedge clk);
        exp_err++;
        chk("err after timeout", err_count, 2);
        chk("bus_wdata kept after timeout", bus_wdata, 8'hA5);
        do_write(8'h44, 8'h5A);
        do_read(8'h44);
        chk("post-timeout readback", last_tx, 8'h5A);

        // gaps just below the timeout must not abort the frame
        exp_wr.push_back(wr_t'{a: 8'h20, d: 8'h77});
        exp_tx.push_back(tx_t'{d: 8'h4B, lat: 2});
        model_mem[8'h20] = 8'h77;
        send_byte(8'h57);
        repeat (60) @(negedge clk);
        send_byte(8'h20);
        repeat (95) @(negedge clk);
        send_byte(8'h77);
        drain();

        send_byte(8'h57);
        send_byte(8'h10);
        send_error();
        drain();
        chk("err after rx_error", err_count, 3);

        tx_busy = 1'b1;
        exp_rd.push_back(8'h22);
        exp_tx.push_back(tx_t'{d: 8'h3C, lat: 0});
        send_byte(8'h52);
        send_byte(8'h22);
        repeat (50) @(negedge clk);
        chk("no tx_wr while busy", exp_tx.size(), 1);
        tx_busy = 1'b0;
        busy_fall = cyc;
        drain();

        send_byte(8'h57);
        send_byte(8'h33);
        reset = 1'b1;
        @(negedge clk);
        check_zero_outputs("mid-frame reset");
        reset = 1'b0;
        exp_err = 0;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        model_mem[8'h22] = 8'h3C;
        repeat (10) @(negedge clk);
        chk("err after reset", err_count, 0);

        for (int i = 0; i < 300; i++) begin
            send_error();
            if (i == 253) begin
                @(negedge clk);
                chk("err count 254", err_count, 254);
            end
        end
        drain();
        chk("err saturated", err_count, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
